// File: rtl/fb_sdram_arbiter.sv
// Double-buffered 256x256x8bpp frame buffer in SDRAM: arbitrates core pixel writes against scan-out reads.
// Latency: at least 4 clk_ram per SDRAM access (grant, strobe, gap, wait-for-rdy); pixel lands 1 cycle after rdy.
// Backpressure: writes queue in a small FIFO and are dropped (sticky wr_overflow) when it is full; reads keep only the newest position.

// Small synchronous FIFO; push is accepted while full if a pop happens in the same cycle.
// Latency: 1 cycle from push to pop_vld; pop_dat is the head entry, combinational.
// Backpressure: push_rdy low only when full with no simultaneous pop.
module fb_sdram_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  input  logic             pop_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign pop_vld  = (count != '0);
  assign do_pop   = pop_rdy && pop_vld;
  assign push_rdy = (count != FULL_CNT) || do_pop;
  assign do_push  = push_vld && push_rdy;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

module fb_sdram_arbiter #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] BASE_ADDR  = 25'h0
) (
  input  logic        clk_ram,
  input  logic        reset,
  input  logic [7:0]  hh,
  input  logic [7:0]  vv,
  input  logic [7:0]  color,
  input  logic        color_ready,
  input  logic        frame,
  input  logic [8:0]  hcount,
  input  logic [8:0]  vcount,
  input  logic        de,
  output logic [24:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic        sdram_rd,
  output logic        sdram_wr,
  input  logic [15:0] sdram_dout,
  input  logic        sdram_rdy,
  output logic [7:0]  pix_out,
  output logic        wr_overflow
);
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
    logic [7:0] color;
  } pix_t;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT} state_t;

  state_t      state;
  logic        cr_q;
  logic        frame_q;
  logic [7:0]  hc_q;
  logic [7:0]  vc_q;
  logic        wr_bank;
  logic        swap_pending;
  logic        rd_pending;
  logic [15:0] rd_xy;
  logic        cur_rd;

  pix_t        push_dat;
  pix_t        pop_dat;
  logic        push_vld;
  logic        push_rdy;
  logic        pop_vld;
  logic        pop_rdy;
  logic        frame_rise;
  logic        rd_chg;

  assign push_vld   = color_ready && !cr_q;
  assign push_dat   = '{y: vv, x: hh, color: color};
  assign frame_rise = frame && !frame_q;
  assign rd_chg     = de && ((hcount[7:0] != hc_q) || (vcount[7:0] != vc_q));
  assign pop_rdy    = (state == IDLE) && !swap_pending && !rd_pending;

  fb_sdram_fifo #(.WIDTH($bits(pix_t)), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk      (clk_ram),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .push_rdy (push_rdy),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .pop_rdy  (pop_rdy)
  );

  function automatic logic [24:0] buf_addr(input logic bank, input logic [15:0] yx);
    return BASE_ADDR + {8'h00, bank, yx};
  endfunction

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state        <= IDLE;
      sdram_rd     <= 1'b0;
      sdram_wr     <= 1'b0;
      sdram_addr   <= '0;
      sdram_din    <= '0;
      pix_out      <= '0;
      wr_overflow  <= 1'b0;
      wr_bank      <= 1'b0;
      swap_pending <= 1'b0;
      rd_pending   <= 1'b0;
      rd_xy        <= '0;
      cur_rd       <= 1'b0;
      // Load edge detectors with the live inputs so a level held through reset is not an edge.
      cr_q         <= color_ready;
      frame_q      <= frame;
      hc_q         <= hcount[7:0];
      vc_q         <= vcount[7:0];
    end else begin
      cr_q    <= color_ready;
      frame_q <= frame;
      hc_q    <= hcount[7:0];
      vc_q    <= vcount[7:0];
      if (push_vld && !push_rdy) wr_overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (swap_pending) begin
            wr_bank      <= ~wr_bank;
            swap_pending <= 1'b0;
          end else if (rd_pending) begin
            // Clearing at grant is equivalent to clearing at completion: a newer change re-arms it below.
            sdram_addr <= buf_addr(~wr_bank, rd_xy);
            sdram_rd   <= 1'b1;
            cur_rd     <= 1'b1;
            rd_pending <= 1'b0;
            state      <= ISSUE;
          end else if (pop_vld) begin
            sdram_addr <= buf_addr(wr_bank, {pop_dat.y, pop_dat.x});
            sdram_din  <= {8'h00, pop_dat.color};
            sdram_wr   <= 1'b1;
            cur_rd     <= 1'b0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          sdram_rd <= 1'b0;
          sdram_wr <= 1'b0;
          state    <= GAP;
        end
        GAP: state <= WAIT;
        WAIT: begin
          if (sdram_rdy) begin
            if (cur_rd) pix_out <= sdram_dout[7:0];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (frame_rise) swap_pending <= 1'b1;
      if (rd_chg) begin
        rd_pending <= 1'b1;
        rd_xy      <= {vcount[7:0], hcount[7:0]};
      end
    end
  end
endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Bench for fb_sdram_arbiter: SDRAM model with variable latency, vector table, corner sequences, random runs.
module tb_fb_sdram_arbiter;
  localparam logic [24:0] BASE = 25'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  hh, vv, color;
  logic        color_ready, frame;
  logic [8:0]  hcount, vcount;
  logic        de;
  logic [24:0] sdram_addr;
  logic [15:0] sdram_din;
  logic        sdram_rd, sdram_wr;
  logic [15:0] sdram_dout;
  logic        sdram_rdy;
  logic [7:0]  pix_out;
  logic        wr_overflow;

  fb_sdram_arbiter #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk_ram(clk), .reset(reset), .hh(hh), .vv(vv), .color(color),
    .color_ready(color_ready), .frame(frame), .hcount(hcount), .vcount(vcount), .de(de),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd), .sdram_wr(sdram_wr),
    .sdram_dout(sdram_dout), .sdram_rdy(sdram_rdy), .pix_out(pix_out), .wr_overflow(wr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [24:0] addr;
    logic [15:0] din;
  } acc_t;

  typedef struct {
    bit          is_rd;
    bit          swap;
    logic [8:0]  h;
    logic [8:0]  v;
    logic [7:0]  c;
    logic [24:0] exp_addr;
    logic [15:0] exp_din;
  } vec_t;

  acc_t acc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat = 3;
  int   busy = 0;
  int   cyc = 0;
  int   last_strobe = -100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input logic [24:0] a);
    logic [7:0] p;
    p = a[7:0] + 8'(a[15:8] * 5);
    if (a[16]) p = p ^ 8'h80;
    return p;
  endfunction

  function automatic logic [24:0] model_addr(input int bank, input int y, input int x);
    return 25'(int'(BASE) + bank * 65536 + y * 256 + x);
  endfunction

  // SDRAM model: logs every strobe, drops rdy for 'lat' cycles, returns a position-derived pixel.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      busy      = 0;
      sdram_rdy = 1'b1;
    end else if (sdram_rd || sdram_wr) begin
      acc_t a;
      chk("strobe_exclusive", {31'b0, sdram_rd && sdram_wr}, 32'd0);
      chk("strobe_spacing", {31'b0, (cyc - last_strobe) >= 4}, 32'd1);
      last_strobe = cyc;
      a.rd   = sdram_rd;
      a.addr = sdram_addr;
      a.din  = sdram_din;
      acc_q.push_back(a);
      if (sdram_rd) sdram_dout = {8'hEE, pix_of(sdram_addr)};
      if (lat > 0) begin
        busy      = lat;
        sdram_rdy = 1'b0;
      end
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) sdram_rdy = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string nm, output acc_t a);
    int i;
    for (i = 0; i < 200 && acc_q.size() == 0; i++) tick(1);
    n_cmp++;
    if (acc_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no SDRAM access within 200 cycles", nm);
      a.rd = 1'b0; a.addr = '0; a.din = '0;
    end else begin
      a = acc_q.pop_front();
    end
  endtask

  task automatic pixel(input logic [7:0] h, input logic [7:0] v, input logic [7:0] c);
    hh = h; vv = v; color = c; color_ready = 1'b1;
    tick(1);
    color_ready = 1'b0;
    tick(1);
  endtask

  task automatic frame_edge();
    frame = 1'b1;
    tick(1);
    frame = 1'b0;
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    acc_t a;
    int   mb;
    logic [7:0] rh, rv, rc;

    tbl[0] = '{0, 0, 9'h012, 9'h034, 8'hA5, 25'h0003412, 16'h00A5};
    tbl[1] = '{0, 1, 9'h012, 9'h034, 8'hA5, 25'h0013412, 16'h00A5};
    tbl[2] = '{1, 0, 9'h005, 9'h002, 8'h00, 25'h0000205, 16'h0000};
    tbl[3] = '{0, 0, 9'h0FF, 9'h0FF, 8'h00, 25'h001FFFF, 16'h0000};
    tbl[4] = '{0, 1, 9'h000, 9'h000, 8'hFF, 25'h0000000, 16'h00FF};
    tbl[5] = '{1, 0, 9'h1AB, 9'h1CD, 8'h00, 25'h001CDAB, 16'h0000};
    tbl[6] = '{1, 1, 9'h003, 9'h004, 8'h00, 25'h0000403, 16'h0000};

    // Levels held high through reset must not look like edges afterwards.
    reset = 1'b1; de = 1'b0; hcount = '0; vcount = '0;
    hh = '0; vv = '0; color = '0; color_ready = 1'b1; frame = 1'b1;
    sdram_rdy = 1'b1; sdram_dout = '0;
    tick(3);
    reset = 1'b0;
    tick(100);
    chk("reset_no_access", acc_q.size(), 0);
    chk("reset_pix_out", pix_out, 0);
    chk("reset_overflow", wr_overflow, 0);
    chk("reset_addr", sdram_addr, 0);
    chk("reset_din", sdram_din, 0);
    color_ready = 1'b0; frame = 1'b0;
    tick(5);
    chk("falling_no_access", acc_q.size(), 0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].swap) begin
        frame_edge();
        tick(3);
      end
      if (!tbl[i].is_rd) begin
        hh = tbl[i].h[7:0]; vv = tbl[i].v[7:0]; color = tbl[i].c; color_ready = 1'b1;
        wait_acc("tbl_wr_wait", a);
        chk("tbl_wr_kind", {31'b0, a.rd}, 0);
        chk("tbl_wr_addr", a.addr, tbl[i].exp_addr);
        chk("tbl_wr_din", a.din, tbl[i].exp_din);
        tick(20);
        chk("tbl_held_ready_single", acc_q.size(), 0);
        color_ready = 1'b0;
        tick(2);
      end else begin
        de = 1'b1; hcount = tbl[i].h; vcount = tbl[i].v;
        wait_acc("tbl_rd_wait", a);
        chk("tbl_rd_kind", {31'b0, a.rd}, 1);
        chk("tbl_rd_addr", a.addr, tbl[i].exp_addr);
        tick(lat + 1);
        chk("tbl_rd_pix", pix_out, pix_of(tbl[i].exp_addr));
        de = 1'b0;
        tick(10);
        chk("tbl_rd_single", acc_q.size(), 0);
      end
    end

    // Read and write both pending when the bus frees: read goes first. wr_bank is 1 here.
    lat = 8;
    de = 1'b1;
    tick(2);
    pixel(8'h01, 8'h01, 8'h11);
    wait_acc("prio_a", a);
    chk("prio_a_addr", a.addr, 25'h0010101);
    pixel(8'h02, 8'h02, 8'h22);
    hcount = 9'h007;
    wait_acc("prio_rd", a);
    chk("prio_rd_kind", {31'b0, a.rd}, 1);
    chk("prio_rd_addr", a.addr, 25'h0000407);
    wait_acc("prio_b", a);
    chk("prio_b_kind", {31'b0, a.rd}, 0);
    chk("prio_b_addr", a.addr, 25'h0010202);
    chk("prio_b_din", a.din, 16'h0022);
    de = 1'b0;
    tick(20);

    // Newer positions overwrite an unserved read: only the last one is fetched.
    de = 1'b1; hcount = 9'h00A; vcount = 9'h00A;
    wait_acc("newest_first", a);
    chk("newest_first_addr", a.addr, 25'h0000A0A);
    hcount = 9'h014; vcount = 9'h014; tick(1);
    hcount = 9'h01E; vcount = 9'h01E; tick(1);
    wait_acc("newest_second", a);
    chk("newest_second_addr", a.addr, 25'h0001E1E);
    tick(lat + 1);
    chk("newest_pix", pix_out, pix_of(25'h0001E1E));
    tick(20);
    chk("newest_no_extra", acc_q.size(), 0);
    de = 1'b0;

    // Fill the FIFO behind a long access: four queue, the fifth is dropped.
    lat = 20;
    pixel(8'h10, 8'h20, 8'h01);
    wait_acc("ovf_p", a);
    lat = 2;
    for (int i = 1; i <= 5; i++) begin
      pixel(8'(8'h30 + i), 8'h40, 8'(i));
      if (i == 4) chk("ovf_not_yet", wr_overflow, 0);
    end
    chk("ovf_set", wr_overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      wait_acc("ovf_drain", a);
      chk("ovf_drain_addr", a.addr, model_addr(1, 8'h40, 8'h30 + i));
      chk("ovf_drain_din", a.din, 16'(i));
    end
    tick(30);
    chk("ovf_fifth_dropped", acc_q.size(), 0);
    chk("ovf_sticky", wr_overflow, 1);

    // Reset during the WAIT of a write abandons it and the queued entry.
    lat = 10;
    pixel(8'h55, 8'h66, 8'h01);
    wait_acc("rst_x", a);
    pixel(8'h56, 8'h66, 8'h02);
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("rst_rd_low", sdram_rd, 0);
    chk("rst_wr_low", sdram_wr, 0);
    tick(1);
    reset = 1'b0;
    lat = 2;
    tick(50);
    chk("rst_no_access", acc_q.size(), 0);
    chk("rst_overflow_clr", wr_overflow, 0);
    chk("rst_pix_clr", pix_out, 0);
    pixel(8'h77, 8'h88, 8'h99);
    wait_acc("rst_bank0", a);
    chk("rst_bank0_addr", a.addr, 25'h0008877);
    chk("rst_bank0_din", a.din, 16'h0099);
    tick(10);

    // Random writes with occasional buffer swaps taken while idle.
    mb = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        tick(8);
        frame_edge();
        mb = 1 - mb;
        tick(3);
      end
      lat = $urandom_range(0, 3);
      rh = 8'($urandom); rv = 8'($urandom); rc = 8'($urandom);
      pixel(rh, rv, rc);
      wait_acc("rnd_wr", a);
      chk("rnd_wr_kind", {31'b0, a.rd}, 0);
      chk("rnd_wr_addr", a.addr, model_addr(mb, rv, rh));
      chk("rnd_wr_din", a.din, {8'h00, rc});
      tick($urandom_range(4, 10));
    end

    // Random display reads from the buffer not being written.
    de = 1'b1;
    for (int i = 0; i < 20; i++) begin
      lat = $urandom_range(0, 3);
      rh = 8'($urandom); rv = 8'($urandom);
      if (rh == hcount[7:0] && rv == vcount[7:0]) rh = rh ^ 8'h01;
      hcount = {1'($urandom_range(0, 1)), rh};
      vcount = {1'($urandom_range(0, 1)), rv};
      wait_acc("rnd_rd", a);
      chk("rnd_rd_kind", {31'b0, a.rd}, 1);
      chk("rnd_rd_addr", a.addr, model_addr(1 - mb, rv, rh));
      tick(lat + 2);
      chk("rnd_rd_pix", pix_out, pix_of(model_addr(1 - mb, rv, rh)));
    end
    de = 1'b0;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
